clock_div_gen: RTL and testbench

//  Generates three independent 50%-duty divided clocks (clk1_o/clk2_o/clk3_o) from one source clock.

---
 rtl/clock_div_gen.sv | 130 +++++++++++++
 tb/tb_clock_div_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_gen.sv
// ============================================================================
// Module  : clock_div_gen
// Purpose : Three independent 50%-duty divided clocks with glitch-free
//           divisor updates and enable/disable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_div_gen #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       en,
    input  logic [2:0]       load,
    input  logic [CNT_W-1:0] div_in,
    output logic             clk1_o,
    output logic             clk2_o,
    output logic             clk3_o,
    output logic [2:0]       running,
    output logic [2:0]       pend
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEF_DIV);

    logic [2:0] out_vec;

    genvar k;
    for (k = 0; k < 3; k++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_act_q, div_act_d;
        logic [CNT_W-1:0] div_pend_q, div_pend_d;
        logic             out_q, out_d;
        logic             pend_q, pend_d;
        logic             period_start;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                out_q      <= 1'b0;
                div_act_q  <= C_DEF_DIV;
                div_pend_q <= '0;
                pend_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                out_q      <= out_d;
                div_act_q  <= div_act_d;
                div_pend_q <= div_pend_d;
                pend_q     <= pend_d;
            end
        end

        always_comb begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            out_d        = out_q;
            div_act_d    = div_act_q;
            div_pend_d   = div_pend_q;
            pend_d       = pend_q;
            period_start = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    out_d = 1'b0;
                    cnt_d = '0;
                    if (en[k]) begin
                        state_d      = ST_RUN;
                        out_d        = 1'b1;
                        period_start = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Disabling is only allowed to cut a low phase, never a high one.
                    if (!out_q && !en[k]) begin
                        state_d = ST_IDLE;
                        out_d   = 1'b0;
                        cnt_d   = '0;
                    end else if (cnt_q == div_act_q) begin
                        cnt_d = '0;
                        out_d = ~out_q;
                        if (out_q) begin
                            if (!en[k]) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            period_start = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase

            // Pending divisor lands only at a period start, so cnt never exceeds div_act.
            if (period_start && pend_q) begin
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
            end
            if (load[k]) begin
                div_pend_d = div_in;
                pend_d     = 1'b1;
            end
        end

        assign out_vec[k] = out_q;
        assign running[k] = (state_q == ST_RUN);
        assign pend[k]    = pend_q;
    end

    assign clk1_o = out_vec[0];
    assign clk2_o = out_vec[1];
    assign clk3_o = out_vec[2];

endmodule

`default_nettype wire

// File: tb/tb_clock_div_gen.sv
// ============================================================================
// Module  : tb_clock_div_gen
// Purpose : Vector table, directed corner sequences and randomized run of
//           clock_div_gen against a phase-countdown reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clock_div_gen;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       en;
    logic [2:0]       load;
    logic [CNT_W-1:0] div_in;
    logic             clk1_o, clk2_o, clk3_o;
    logic [2:0]       running, pend;

    int checks = 0;
    int errors = 0;

    clock_div_gen #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .clk1_o  (clk1_o),
        .clk2_o  (clk2_o),
        .clk3_o  (clk3_o),
        .running (running),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    // Reference model: each channel counts down the cycles left in its phase.
    bit m_act [3];
    bit m_lvl [3];
    int m_rem [3];
    int m_div [3];
    int m_pv  [3];
    bit m_pf  [3];

    function automatic void model_step();
        bit start;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                m_act[c] = 0; m_lvl[c] = 0; m_rem[c] = 0;
                m_div[c] = DEF_DIV; m_pf[c] = 0;
                continue;
            end
            start = 0;
            if (!m_act[c]) begin
                if (en[c]) begin
                    m_act[c] = 1; m_lvl[c] = 1; start = 1;
                end
            end else if (!m_lvl[c] && !en[c]) begin
                m_act[c] = 0;
            end else if (m_rem[c] == 1) begin
                if (m_lvl[c]) begin
                    m_lvl[c] = 0;
                    if (!en[c]) m_act[c] = 0;
                    else        m_rem[c] = m_div[c] + 1;
                end else begin
                    m_lvl[c] = 1; start = 1;
                end
            end else begin
                m_rem[c] = m_rem[c] - 1;
            end
            if (start) begin
                if (m_pf[c]) begin
                    m_div[c] = m_pv[c]; m_pf[c] = 0;
                end
                m_rem[c] = m_div[c] + 1;
            end
            if (load[c]) begin
                m_pv[c] = int'(div_in); m_pf[c] = 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {clk3_o, clk2_o, clk1_o, running, pend};
    endfunction

    function automatic logic [8:0] model_vec();
        logic [8:0] v;
        for (int c = 0; c < 3; c++) begin
            v[6+c] = m_lvl[c];
            v[3+c] = m_act[c];
            v[c]   = m_pf[c];
        end
        return v;
    endfunction

    function automatic logic cur_clk(input int c);
        case (c)
            0:       return clk1_o;
            1:       return clk2_o;
            default: return clk3_o;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", {23'd0, dut_vec()}, {23'd0, model_vec()});
    endtask

    task automatic wait_rise(input int c, output int n);
        logic prev;
        n    = 0;
        prev = cur_clk(c);
        for (int i = 0; i < 1000; i++) begin
            tick();
            n++;
            if (!prev && cur_clk(c)) return;
            prev = cur_clk(c);
        end
        n = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; load = '0; div_in = '0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] en;
        logic [2:0] load;
        logic [7:0] div;
        logic [2:0] clk;
        logic [2:0] run;
        logic [2:0] pnd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n, hi, rises0, rises2;
        logic seen_high, p0, p2;

        rst = 1'b1; en = '0; load = '0; div_in = '0;

        tbl[0]  = '{1'b1, 3'b000, 3'b000, 8'd0, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b001, 3'b001, 3'b000};
        tbl[2]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b001, 3'b001, 3'b000};
        tbl[3]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b000, 3'b001, 3'b000};
        tbl[4]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b000, 3'b001, 3'b000};
        tbl[5]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b001, 3'b001, 3'b000};
        tbl[6]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b001, 3'b001, 3'b000};
        tbl[7]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b000, 3'b001, 3'b000};
        tbl[8]  = '{1'b0, 3'b001, 3'b001, 8'd5, 3'b000, 3'b001, 3'b001};
        tbl[9]  = '{1'b0, 3'b001, 3'b000, 8'd0, 3'b001, 3'b001, 3'b000};
        tbl[10] = '{1'b0, 3'b000, 3'b000, 8'd0, 3'b001, 3'b001, 3'b000};

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load; div_in = tbl[i].div;
            tick();
            check($sformatf("tbl%0d_clk", i), {29'd0, clk3_o, clk2_o, clk1_o}, {29'd0, tbl[i].clk});
            check($sformatf("tbl%0d_run", i), {29'd0, running}, {29'd0, tbl[i].run});
            check($sformatf("tbl%0d_pend", i), {29'd0, pend}, {29'd0, tbl[i].pnd});
        end

        // Load during a high phase: current period keeps old divisor.
        do_reset();
        en = 3'b001; tick();
        load = 3'b001; div_in = 8'd2; tick(); load = '0;
        check("t2_pend_set", {31'd0, pend[0]}, 32'd1);
        wait_rise(0, n);
        check("t2_old_period_rest", n, 3);
        check("t2_pend_cleared", {31'd0, pend[0]}, 32'd0);
        wait_rise(0, n);
        check("t2_new_period", n, 6);

        // Disable mid high phase: high completes, then channel idles.
        do_reset();
        load = 3'b010; div_in = 8'd3; tick(); load = '0;
        en = 3'b010; tick();
        check("t3_rise", {31'd0, clk2_o}, 32'd1);
        en = 3'b000; tick();
        hi = 2;
        for (int i = 0; i < 50 && clk2_o; i++) begin
            tick();
            if (clk2_o) hi++;
        end
        check("t3_high_len", hi, 4);
        check("t3_running_off", {31'd0, running[1]}, 32'd0);
        seen_high = 1'b0;
        repeat (20) begin
            tick();
            if (clk2_o) seen_high = 1'b1;
        end
        check("t3_stays_low", {31'd0, seen_high}, 32'd0);

        // Simultaneous enable with D=0,1,2.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            load = 3'(1 << c); div_in = 8'(c); tick();
        end
        load = '0; en = 3'b111; tick();
        check("t4_aligned_rise", {29'd0, clk3_o, clk2_o, clk1_o}, 32'h7);
        rises0 = 0; rises2 = 0;
        for (int t = 0; t < 12; t++) begin
            p0 = clk1_o; p2 = clk3_o;
            tick();
            if (!p0 && clk1_o) rises0++;
            if (!p2 && clk3_o) rises2++;
        end
        check("t4_realign", {29'd0, clk3_o, clk2_o, clk1_o}, 32'h7);
        check("t4_ch0_rises", rises0, 6);
        check("t4_ch2_rises", rises2, 2);

        // Load on the very edge a pending divisor is applied.
        do_reset();
        en = 3'b100; tick();
        load = 3'b100; div_in = 8'd3; tick(); load = '0;
        tick(); tick();
        load = 3'b100; div_in = 8'd5; tick(); load = '0;
        check("t5_rise", {31'd0, clk3_o}, 32'd1);
        check("t5_pend_kept", {31'd0, pend[2]}, 32'd1);
        wait_rise(2, n);
        check("t5_period_old_pend", n, 8);
        check("t5_pend_cleared", {31'd0, pend[2]}, 32'd0);
        wait_rise(2, n);
        check("t5_period_new", n, 12);

        // Reset during a high phase.
        do_reset();
        load = 3'b010; div_in = 8'd6; tick(); load = '0;
        en = 3'b111; tick();
        load = 3'b001; div_in = 8'd9; tick(); load = '0;
        rst = 1'b1; en = '0; tick(); rst = 1'b0;
        check("t6_after_rst", {23'd0, dut_vec()}, 32'd0);
        en = 3'b001; tick();
        wait_rise(0, n);
        check("t6_def_div", n, 4);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
                load[c] = ($urandom_range(0, 11) == 0);
            end
            div_in = ($urandom_range(0, 49) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
